aesl_deadlock_watchdog: RTL

// Downstream consumer of the AESL deadlock monitor's block/axis_block_info outputs.

---
 rtl/aesl_deadlock_pkg.sv | 11 +
 rtl/aesl_deadlock_watchdog_if.sv | 14 +
 rtl/aesl_sat_counter.sv | 18 +
 rtl/aesl_deadlock_watchdog.sv | 101 ++++++++++
 4 files changed

// File: rtl/aesl_deadlock_pkg.sv
// aesl_deadlock_pkg: shared types and constants for the AESL deadlock watchdog
package aesl_deadlock_pkg;
  localparam int unsigned AXIS_INFO_W = 2;
  localparam int unsigned DEF_NUM_AXIS = 2;
  localparam int unsigned DEF_STAMP_W = 32;
  typedef enum logic [1:0] {IDLE, SUSPECT, CONFIRMED, DONE} wd_state_e;
  typedef struct packed {
    logic [AXIS_INFO_W*DEF_NUM_AXIS-1:0] info;
    logic [DEF_STAMP_W-1:0]              stamp;
  } report_t;
endpackage

// File: rtl/aesl_deadlock_watchdog_if.sv
// aesl_deadlock_watchdog_if: report valid/ready channel from watchdog to reporter
interface aesl_deadlock_watchdog_if
  import aesl_deadlock_pkg::*;
#(
  parameter int unsigned NUM_AXIS = DEF_NUM_AXIS,
  parameter int unsigned STAMP_W  = DEF_STAMP_W
);
  logic                            report_valid;
  logic                            report_ready;
  logic [AXIS_INFO_W*NUM_AXIS-1:0] report_info;
  logic [STAMP_W-1:0]              report_stamp;
  modport master (output report_valid, report_info, report_stamp, input report_ready);
  modport slave (input report_valid, report_info, report_stamp, output report_ready);
endinterface

// File: rtl/aesl_sat_counter.sv
// aesl_sat_counter: up-counter that sticks at MAX; clr wins over inc
module aesl_sat_counter #(
  parameter int unsigned W   = 8,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : (inc && cnt_q != MAX) ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/aesl_deadlock_watchdog.sv
// aesl_deadlock_watchdog: qualifies the monitor's block flag and issues one report per episode.
// Define AESL_DEADLOCK_HIST_EN to add the transient_cnt abort counter output.
module aesl_deadlock_watchdog
  import aesl_deadlock_pkg::*;
#(
  parameter int unsigned NUM_AXIS  = 2,
  parameter int unsigned THRESHOLD = 1024,
  parameter int unsigned STAMP_W   = 32
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic                            block,
  input  logic [AXIS_INFO_W*NUM_AXIS-1:0] axis_block_info,
  input  logic                            clear,
  aesl_deadlock_watchdog_if.master        rpt,
`ifdef AESL_DEADLOCK_HIST_EN
  output logic [15:0]                     transient_cnt,
`endif
  output logic                            deadlock
);
  localparam int unsigned INFO_W = AXIS_INFO_W * NUM_AXIS;
  localparam int unsigned CNT_W = $clog2(THRESHOLD + 1);
  localparam logic [CNT_W-1:0] HIT_AT = CNT_W'(THRESHOLD - 1);
  typedef struct packed {
    logic [INFO_W-1:0]  info;
    logic [STAMP_W-1:0] stamp;
  } rpt_t;
  wd_state_e          state_q, state_d;
  logic [CNT_W-1:0]   run;
  logic               run_inc, run_clr, hit, confirm;
  logic [INFO_W-1:0]  acc_q, acc_d;
  logic [STAMP_W-1:0] stamp_q, onset_q, onset_d;
  rpt_t               rpt_q, rpt_d;
  logic               valid_q, valid_d, dl_q, dl_d;
  aesl_sat_counter #(.W(CNT_W), .MAX(CNT_W'(THRESHOLD))) u_run (
    .clock, .reset_n, .inc(run_inc), .clr(run_clr), .cnt(run)
  );
  // run is 0 in IDLE, so the same compare covers THRESHOLD==1 straight from IDLE
  assign hit = run == HIT_AT;
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    onset_d = onset_q;
    run_inc = 1'b0;
    run_clr = 1'b0;
    if (clear) begin
      state_d = IDLE;
      acc_d   = '0;
      run_clr = 1'b1;
    end else begin
      case (state_q)
        IDLE, SUSPECT:
          if (block) begin
            run_inc = 1'b1;
            acc_d   = (state_q == SUSPECT ? acc_q : '0) | axis_block_info;
            onset_d = state_q == IDLE ? stamp_q : onset_q;
            state_d = hit ? CONFIRMED : SUSPECT;
          end else begin
            state_d = IDLE;
            acc_d   = '0;
            run_clr = 1'b1;
          end
        CONFIRMED: state_d = (valid_q && rpt.report_ready) ? DONE : CONFIRMED;
        default: ;
      endcase
    end
    confirm = state_d == CONFIRMED && state_q != CONFIRMED;
    rpt_d   = confirm ? '{info: acc_d, stamp: onset_d} : rpt_q;
    valid_d = state_d == CONFIRMED;
    dl_d    = state_d == CONFIRMED || state_d == DONE;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      stamp_q <= '0;
      onset_q <= '0;
      rpt_q   <= '0;
      valid_q <= 1'b0;
      dl_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      stamp_q <= stamp_q + STAMP_W'(1);
      onset_q <= onset_d;
      rpt_q   <= rpt_d;
      valid_q <= valid_d;
      dl_q    <= dl_d;
    end
  assign rpt.report_valid = valid_q;
  assign rpt.report_info  = rpt_q.info;
  assign rpt.report_stamp = rpt_q.stamp;
  assign deadlock         = dl_q;
`ifdef AESL_DEADLOCK_HIST_EN
  logic abort;
  assign abort = state_q == SUSPECT && !block && !clear;
  aesl_sat_counter #(.W(16), .MAX(16'hFFFF)) u_hist (
    .clock, .reset_n, .inc(abort), .clr(1'b0), .cnt(transient_cnt)
  );
`endif
endmodule
